// File: rtl/rf_read_scheduler.sv
// Round-robin arbiter for four readers sharing one regfile read port.
// A grant is made combinationally, and the result is registered one cycle later with write bypass.
module rf_read_scheduler (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [3:0]  req,
  input  logic [19:0] req_addr,
  input  logic        stall,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_data_in,
  output logic [4:0]  rd_select,
  output logic [3:0]  gnt,
  output logic [3:0]  rsp_valid,
  output logic [31:0] rsp_data
);

  logic [1:0]  ptr_r;
  logic [3:0]  rsp_valid_r;
  logic [31:0] rsp_data_r;

  logic        found_s;
  logic [1:0]  win_s;
  logic [1:0]  idx_s;
  logic [3:0]  gnt_s;
  logic [4:0]  sel_s;
  logic [31:0] result_s;

  // Winner search from ptr upward; reset and stall suppress any grant.
  always_comb begin
    found_s = 1'b0;
    win_s   = 2'd0;
    idx_s   = 2'd0;
    gnt_s   = 4'b0000;
    sel_s   = 5'd0;
    if (ctrl_reset_n && !stall) begin
      for (int k = 0; k < 4; k++) begin
        idx_s = ptr_r + k[1:0];
        if (!found_s && req[idx_s]) begin
          found_s = 1'b1;
          win_s   = idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
    if (found_s) begin
      gnt_s[win_s] = 1'b1;
      sel_s        = req_addr[5*win_s +: 5];
    end else begin
      sel_s = 5'd0;
    end
  end

  // Register 0 reads as zero; a same-cycle write to the selected register wins over the array.
  always_comb begin
    result_s = rd_data_in;
    if (sel_s == 5'd0) begin
      result_s = 32'h0000_0000;
    end else if (wr_en && (wr_addr == sel_s)) begin
      result_s = wr_data;
    end else begin
      result_s = rd_data_in;
    end
  end

  // Pointer advance and one-cycle response pulse; reset drops any in-flight response.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      ptr_r       <= 2'd0;
      rsp_valid_r <= 4'b0000;
      rsp_data_r  <= 32'h0000_0000;
    end else if (found_s) begin
      ptr_r       <= win_s + 2'd1;
      rsp_valid_r <= gnt_s;
      rsp_data_r  <= result_s;
    end else begin
      rsp_valid_r <= 4'b0000;
    end
  end

  assign gnt       = gnt_s;
  assign rd_select = sel_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: doc/rf_read_scheduler.md
RF_READ_SCHEDULER -- requirements
Module: rf_read_scheduler

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: ctrl_reset_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: req  input  4  per-requester read request; requester i holds req[i] high until granted.
REQ-004 SHALL have port: req_addr  input  20  packed register numbers; requester i uses bits [5i+4:5i].
REQ-005 SHALL have port: stall  input  1  high blocks new grants (regfile port busy).
REQ-006 SHALL have port: wr_en  input  1  regfile write enable this cycle, snooped for bypass.
REQ-007 SHALL have port: wr_addr  input  5  regfile write register number.
REQ-008 SHALL have port: wr_data  input  32  regfile write data.
REQ-009 SHALL have port: rd_data_in  input  32  data returned by the 32:1 regfile read mux for rd_select.
REQ-010 SHALL have port: rd_select  output  5  register select driven to the read mux.
REQ-011 SHALL have port: gnt  output  4  one-hot grant, combinational, same cycle as the sampled request.
REQ-012 SHALL have port: rsp_valid  output  4  one-hot registered response strobe.
REQ-013 SHALL have port: rsp_data  output  32  registered read result.

Function
REQ-014 SHALL issue at most one grant per cycle; gnt SHALL be 4'b0000 when stall=1, when req=4'b0000, or while ctrl_reset_n=0.
REQ-015 SHALL choose the winner round-robin: the first requester with req[i]=1 searching from pointer ptr (2 bits) upward, wrapping 3->0.
REQ-016 SHALL, on a grant to requester w, update ptr to (w+1) mod 4 at the next edge; ptr SHALL be unchanged in cycles with no grant.
REQ-017 SHALL drive rd_select = req_addr of the winner in the grant cycle and 5'd0 in non-grant cycles.
REQ-018 SHALL register the result at the end of the grant cycle N; rsp_valid[w]=1 and rsp_data valid in cycle N+1 only (latency 1, one-cycle pulse).
REQ-019 SHALL compute the registered result with priority: selected address 0 -> 32'h00000000; else wr_en=1 and wr_addr equals selected address -> wr_data (same-cycle write bypass); else rd_data_in.
REQ-020 SHALL hold rsp_data at its last value and drive rsp_valid=4'b0000 in cycles following a non-grant cycle.
REQ-021 SHALL support back-to-back grants every cycle; consecutive grants to different requesters produce consecutive rsp_valid pulses.
REQ-022 SHALL grant a single continuously requesting requester on every non-stalled cycle (no forced idle).
REQ-023 SHALL guarantee that any requester holding req high is granted within 4 non-stalled cycles.
REQ-024 SHALL ignore req_addr of non-winning requesters and ignore wr_* except for the bypass compare.
REQ-025 SHALL treat a stall asserted in the cycle after a grant as not affecting that grant's response.

Reset
REQ-026 SHALL, on a clock edge with ctrl_reset_n=0, set ptr=0, rsp_valid=4'b0000, rsp_data=32'h00000000.
REQ-027 SHALL drop an in-flight response: a grant in the cycle reset is sampled produces no rsp_valid afterwards.
REQ-028 SHALL, in the first cycle after reset release, grant the lowest-numbered active requester (ptr=0).

Verification
REQ-029 SHALL pass: after reset, req=4'b0001, addr0=5'd7, rd_data_in=32'hDEADBEEF -> gnt=4'b0001, rd_select=7; next cycle rsp_valid=4'b0001, rsp_data=32'hDEADBEEF.
REQ-030 SHALL pass: req=4'b1111 held 8 cycles, no stall -> gnt sequence 0001,0010,0100,1000,0001,... and rsp_valid the same sequence delayed one cycle.
REQ-031 SHALL pass: req=4'b0100, addr2=5'd9, wr_en=1, wr_addr=9, wr_data=32'h12345678, rd_data_in=32'h0 -> next-cycle rsp_data=32'h12345678.
REQ-032 SHALL pass: req=4'b0010, addr1=5'd0, rd_data_in=32'hFFFFFFFF, wr_en=1, wr_addr=0 -> next-cycle rsp_data=32'h00000000.
REQ-033 SHALL pass: req=4'b0011 with stall=1 for 3 cycles -> gnt=0000, rsp_valid=0000, ptr unchanged; stall drops -> gnt=0001.
REQ-034 SHALL pass: grant to requester 3 with ctrl_reset_n=0 same cycle -> rsp_valid stays 4'b0000, rsp_data=32'h0; after release req=4'b1001 -> gnt=4'b0001.
